// File: rtl/mem_port_arbiter.sv
`default_nettype none
// ============================================================================
// Module      : mem_port_arbiter
// Description : Round-robin arbiter sharing one data-cache port between
//               NUM_REQ load/store requesters. Each access runs through
//               ISSUE, an optional WAIT_FILL bounded by a watchdog, and DONE,
//               which returns a one-cycle done pulse plus read data.
// Revision    : 1.0 - initial release
// ============================================================================
module mem_port_arbiter #(
   parameter int NUM_REQ = 4,
   parameter int ADDR_W  = 12,
   parameter int DATA_W  = 8,
   parameter int TIMEOUT = 15
) (
   input  logic                        clk,
   input  logic                        rst,
   input  logic [NUM_REQ-1:0]          req,
   input  logic [NUM_REQ-1:0]          we,
   input  logic [NUM_REQ*ADDR_W-1:0]   addr,
   input  logic [NUM_REQ*DATA_W-1:0]   wdata,
   output logic [NUM_REQ-1:0]          done,
   output logic                        err,
   output logic [DATA_W-1:0]           rdata,
   output logic                        cache_valid,
   output logic                        cache_we,
   output logic [ADDR_W-1:0]           cache_addr,
   output logic [DATA_W-1:0]           cache_wdata,
   input  logic                        cache_hit,
   input  logic                        cache_ready,
   input  logic [DATA_W-1:0]           cache_rdata
);

   localparam int IDX_W = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1;

   typedef enum logic [1:0] {
      IDLE      = 2'd0,
      ISSUE     = 2'd1,
      WAIT_FILL = 2'd2,
      DONE      = 2'd3
   } state_t;

   state_t             state;
   logic [IDX_W-1:0]   ptr;
   logic [IDX_W-1:0]   owner;
   logic               owner_we;
   logic [ADDR_W-1:0]  owner_addr;
   logic [DATA_W-1:0]  owner_wdata;
   logic [7:0]         count;

   logic [ADDR_W-1:0]  addr_arr  [NUM_REQ];
   logic [DATA_W-1:0]  wdata_arr [NUM_REQ];

   logic               sel_found;
   logic [IDX_W-1:0]   sel_idx;
   logic [IDX_W:0]     cand;

   // Split the packed request buses into per-requester slices
   for (genvar gi = 0; gi < NUM_REQ; gi++) begin : g_unpack
      assign addr_arr[gi]  = addr[gi*ADDR_W +: ADDR_W];
      assign wdata_arr[gi] = wdata[gi*DATA_W +: DATA_W];
   end

   // Pick the first active requester at or after ptr, wrapping around
   always_comb begin
      sel_found = 1'b0;
      sel_idx   = '0;
      cand      = '0;
      for (int i = 0; i < NUM_REQ; i++) begin
         cand = {1'b0, ptr} + (IDX_W+1)'(i);
         if (cand >= (IDX_W+1)'(NUM_REQ)) begin
            cand = cand - (IDX_W+1)'(NUM_REQ);
         end
         if (!sel_found && req[cand[IDX_W-1:0]]) begin
            sel_found = 1'b1;
            sel_idx   = cand[IDX_W-1:0];
         end
      end
   end

   // Access sequencer; every output is registered and set on the edge that
   // enters the state in which it is defined, so it clears on the next edge
   always_ff @(posedge clk) begin
      if (rst) begin
         state       <= IDLE;
         ptr         <= '0;
         owner       <= '0;
         owner_we    <= 1'b0;
         owner_addr  <= '0;
         owner_wdata <= '0;
         count       <= '0;
         done        <= '0;
         err         <= 1'b0;
         rdata       <= '0;
         cache_valid <= 1'b0;
         cache_we    <= 1'b0;
         cache_addr  <= '0;
         cache_wdata <= '0;
      end else begin
         done        <= '0;
         err         <= 1'b0;
         rdata       <= '0;
         cache_valid <= 1'b0;
         cache_we    <= 1'b0;
         cache_addr  <= '0;
         cache_wdata <= '0;
         case (state)
            IDLE: begin
               if (sel_found) begin
                  owner       <= sel_idx;
                  owner_we    <= we[sel_idx];
                  owner_addr  <= addr_arr[sel_idx];
                  owner_wdata <= wdata_arr[sel_idx];
                  cache_valid <= 1'b1;
                  cache_we    <= we[sel_idx];
                  cache_addr  <= addr_arr[sel_idx];
                  cache_wdata <= wdata_arr[sel_idx];
                  state       <= ISSUE;
               end
            end
            ISSUE: begin
               if (cache_hit) begin
                  done  <= {{(NUM_REQ-1){1'b0}}, 1'b1} << owner;
                  rdata <= owner_we ? '0 : cache_rdata;
                  state <= DONE;
               end else begin
                  count <= '0;
                  state <= WAIT_FILL;
               end
            end
            WAIT_FILL: begin
               count <= count + 8'd1;
               // A fill arriving in the watchdog's final cycle still wins
               if (cache_ready) begin
                  done  <= {{(NUM_REQ-1){1'b0}}, 1'b1} << owner;
                  rdata <= owner_we ? '0 : cache_rdata;
                  state <= DONE;
               end else if (count == 8'(TIMEOUT)) begin
                  done  <= {{(NUM_REQ-1){1'b0}}, 1'b1} << owner;
                  err   <= 1'b1;
                  state <= DONE;
               end
            end
            DONE: begin
               ptr   <= (owner == IDX_W'(NUM_REQ-1)) ? '0 : owner + IDX_W'(1);
               state <= IDLE;
            end
            default: state <= IDLE;
         endcase
      end
   end

endmodule
`default_nettype wire

// File: tb/tb_mem_port_arbiter.sv
`default_nettype none
// ============================================================================
// Module      : tb_mem_port_arbiter
// Description : Scoreboard bench for mem_port_arbiter. Expected cache
//               accesses and completions are queued as stimulus is driven
//               and compared when the DUT produces them.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_mem_port_arbiter;

   localparam int NUM_REQ = 4;
   localparam int ADDR_W  = 12;
   localparam int DATA_W  = 8;
   localparam int TIMEOUT = 15;

   typedef struct {
      logic              we;
      logic [ADDR_W-1:0] addr;
      logic [DATA_W-1:0] wdata;
      int                due;
   } acc_t;

   typedef struct {
      int                idx;
      logic              err;
      logic [DATA_W-1:0] rdata;
      int                due;
   } comp_t;

   logic                      clk = 1'b0;
   logic                      rst;
   logic [NUM_REQ-1:0]        req;
   logic [NUM_REQ-1:0]        we;
   logic [NUM_REQ*ADDR_W-1:0] addr;
   logic [NUM_REQ*DATA_W-1:0] wdata;
   logic [NUM_REQ-1:0]        done;
   logic                      err;
   logic [DATA_W-1:0]         rdata;
   logic                      cache_valid;
   logic                      cache_we;
   logic [ADDR_W-1:0]         cache_addr;
   logic [DATA_W-1:0]         cache_wdata;
   logic                      cache_hit;
   logic                      cache_ready;
   logic [DATA_W-1:0]         cache_rdata;

   int    cyc     = 0;
   int    nchk    = 0;
   int    nerr    = 0;
   bit    mon_en  = 1'b0;
   acc_t  acc_q[$];
   comp_t comp_q[$];
   acc_t  mon_a;
   comp_t mon_c;

   mem_port_arbiter #(
      .NUM_REQ(NUM_REQ), .ADDR_W(ADDR_W), .DATA_W(DATA_W), .TIMEOUT(TIMEOUT)
   ) dut (
      .clk(clk), .rst(rst), .req(req), .we(we), .addr(addr), .wdata(wdata),
      .done(done), .err(err), .rdata(rdata),
      .cache_valid(cache_valid), .cache_we(cache_we), .cache_addr(cache_addr),
      .cache_wdata(cache_wdata), .cache_hit(cache_hit),
      .cache_ready(cache_ready), .cache_rdata(cache_rdata)
   );

   always #5 clk = ~clk;

   // Cycle counter used to time-stamp expected events
   always @(posedge clk) cyc <= cyc + 1;

   task automatic check_eq(input string tag, input logic [63:0] got, input logic [63:0] exp);
      nchk++;
      if (got !== exp) begin
         nerr++;
         $display("FAIL %s: got=%0h expected=%0h (cycle %0d)", tag, got, exp, cyc);
      end
   endtask

   // Compare DUT outputs against the scoreboard away from the active edge
   always @(negedge clk) begin
      if (mon_en) begin
         if (cache_valid) begin
            if (acc_q.size() == 0) begin
               check_eq("unexpected_access", 64'd1, 64'd0);
            end else begin
               mon_a = acc_q.pop_front();
               check_eq("access_cycle", 64'(cyc), 64'(mon_a.due));
               check_eq("cache_we", 64'(cache_we), 64'(mon_a.we));
               check_eq("cache_addr", 64'(cache_addr), 64'(mon_a.addr));
               check_eq("cache_wdata", 64'(cache_wdata), 64'(mon_a.wdata));
            end
         end else begin
            check_eq("cache_idle", 64'({cache_we, cache_addr, cache_wdata}), 64'd0);
         end
         if (done != '0) begin
            if (comp_q.size() == 0) begin
               check_eq("unexpected_done", 64'(done), 64'd0);
            end else begin
               mon_c = comp_q.pop_front();
               check_eq("done_cycle", 64'(cyc), 64'(mon_c.due));
               check_eq("done_onehot", 64'(done), 64'd1 << mon_c.idx);
               check_eq("err", 64'(err), 64'(mon_c.err));
               check_eq("rdata", 64'(rdata), 64'(mon_c.rdata));
            end
         end else begin
            check_eq("done_idle", 64'({err, rdata}), 64'd0);
         end
      end
   end

   task automatic set_req(input int idx, input logic w, input logic [ADDR_W-1:0] a,
                          input logic [DATA_W-1:0] wd);
      req[idx]                  = 1'b1;
      we[idx]                   = w;
      addr[idx*ADDR_W +: ADDR_W] = a;
      wdata[idx*DATA_W +: DATA_W] = wd;
   endtask

   // One access by a single requester; k is the number of WAIT_FILL cycles on a miss
   task automatic run_access(input int idx, input logic w, input logic [ADDR_W-1:0] a,
                             input logic [DATA_W-1:0] wd, input logic hit, input int k,
                             input logic ready_ever, input logic [DATA_W-1:0] rd);
      int    c;
      acc_t  ea;
      comp_t ec;
      c = cyc;
      set_req(idx, w, a, wd);
      cache_hit   = hit;
      cache_ready = 1'b0;
      cache_rdata = rd;
      ea.we = w; ea.addr = a; ea.wdata = wd; ea.due = c + 1;
      acc_q.push_back(ea);
      ec.idx   = idx;
      ec.err   = !hit && !ready_ever;
      ec.rdata = (w || ec.err) ? '0 : rd;
      ec.due   = c + 2 + (hit ? 0 : k);
      comp_q.push_back(ec);
      @(posedge clk) #1;
      // Access is latched now; later changes must not leak into it
      addr[idx*ADDR_W +: ADDR_W]  = ~a;
      wdata[idx*DATA_W +: DATA_W] = ~wd;
      we[idx]                     = ~w;
      @(posedge clk) #1;
      if (!hit) begin
         for (int j = 1; j <= k; j++) begin
            cache_ready = ready_ever && (j == k);
            @(posedge clk) #1;
         end
      end
      cache_ready = 1'b0;
      req[idx]    = 1'b0;
      @(posedge clk) #1;
   endtask

   initial begin
      #200000;
      $display("FAIL watchdog: simulation did not finish, got=running expected=finished");
      $fatal(1, "watchdog expired");
   end

   initial begin
      int    c;
      acc_t  ea;
      comp_t ec;
      rst = 1'b1; req = '0; we = '0; addr = '0; wdata = '0;
      cache_hit = 1'b0; cache_ready = 1'b0; cache_rdata = '0;
      repeat (3) @(posedge clk);
      @(negedge clk);
      check_eq("reset_out", 64'({done, err, rdata, cache_valid, cache_we}), 64'd0);
      check_eq("reset_cache", 64'({cache_addr, cache_wdata}), 64'd0);
      @(posedge clk) #1;
      rst    = 1'b0;
      mon_en = 1'b1;

      // Round-robin with all four requesters held and every access hitting
      c = cyc;
      for (int i = 0; i < NUM_REQ; i++) set_req(i, 1'b0, ADDR_W'(12'h100 + i), DATA_W'(i));
      cache_hit = 1'b1; cache_rdata = 8'h3C;
      for (int n = 0; n < 5; n++) begin
         ea.we = 1'b0; ea.addr = ADDR_W'(12'h100 + (n % NUM_REQ));
         ea.wdata = DATA_W'(n % NUM_REQ); ea.due = c + 1 + 3*n;
         acc_q.push_back(ea);
         ec.idx = n % NUM_REQ; ec.err = 1'b0; ec.rdata = 8'h3C; ec.due = c + 2 + 3*n;
         comp_q.push_back(ec);
      end
      while (cyc < c + 14) @(posedge clk) #1;
      req = '0;
      @(posedge clk) #1;

      // Single load hit
      run_access(0, 1'b0, 12'h123, 8'h00, 1'b1, 0, 1'b0, 8'h5A);
      // Store miss, fill on the third WAIT_FILL cycle
      run_access(2, 1'b1, 12'h456, 8'hC3, 1'b0, 3, 1'b1, 8'h99);
      // Load miss with a two-cycle fill
      run_access(3, 1'b0, 12'h789, 8'h11, 1'b0, 2, 1'b1, 8'hA7);
      // Watchdog expiry: done and err TIMEOUT+2 cycles after ISSUE
      run_access(3, 1'b0, 12'hABC, 8'h22, 1'b0, TIMEOUT + 1, 1'b0, 8'hEE);
      // Next request is served normally
      run_access(1, 1'b0, 12'h2AA, 8'h33, 1'b1, 0, 1'b0, 8'h91);
      // Fill arriving in the same cycle the watchdog expires
      run_access(0, 1'b0, 12'h0F0, 8'h44, 1'b0, TIMEOUT + 1, 1'b1, 8'h77);

      // Reset while waiting for a fill: access aborted without a done pulse
      c = cyc;
      set_req(1, 1'b0, 12'h5A5, 8'h55);
      cache_hit = 1'b0; cache_ready = 1'b0; cache_rdata = 8'h66;
      ea.we = 1'b0; ea.addr = 12'h5A5; ea.wdata = 8'h55; ea.due = c + 1;
      acc_q.push_back(ea);
      repeat (3) @(posedge clk) #1;
      rst = 1'b1;
      @(posedge clk);
      @(negedge clk);
      check_eq("rst_mid_out", 64'({done, err, rdata, cache_valid, cache_we}), 64'd0);
      check_eq("rst_mid_cache", 64'({cache_addr, cache_wdata}), 64'd0);
      @(posedge clk) #1;
      rst = 1'b0;
      c = cyc;
      cache_hit = 1'b1; cache_rdata = 8'h4E;
      ea.due = c + 1;
      acc_q.push_back(ea);
      ec.idx = 1; ec.err = 1'b0; ec.rdata = 8'h4E; ec.due = c + 2;
      comp_q.push_back(ec);
      repeat (2) @(posedge clk) #1;
      req = '0;
      repeat (4) @(posedge clk) #1;

      check_eq("acc_left", 64'(acc_q.size()), 64'd0);
      check_eq("comp_left", 64'(comp_q.size()), 64'd0);
      mon_en = 1'b0;
      $display("Result: errors=%0d of %0d checks", nerr, nchk);
      $finish;
   end

endmodule
`default_nettype wire
